axi_burst_checker: RTL and testbench
====================================

// Module: axi_burst_checker
// PURPOSE
//  Parametrised AXI4 master self-test engine: writes NUM_BURSTS INCR bursts of a known pattern
//  to an external AXI4 slave (memory model or DUT), reads them back, compares every beat.
//  Reports sticky done/error plus a mismatch count; successor to the fixed single-run demo.
//  Sits at the top of demo/bring-up benches and in FPGA self-test wrappers.
// PARAMETERS
//  ADDR_WIDTH   32          AXI address width
//  DATA_WIDTH   32          AXI data width; power of two, 8..256
//  BURST_LEN    4           beats per burst, 1..256 (AxLEN = BURST_LEN-1)
//  NUM_BURSTS   4           bursts per run, >=1
//  BASE_ADDR    'h0         first burst address; bursts must not cross a 4 KB boundary
//  PATTERN_MODE 0           0 = incrementing (SEED+beat), 1 = 32-bit Galois LFSR, replicated to DATA_WIDTH
//  SEED         'h1         pattern seed; LFSR seed must be non-zero
// PORTS
//  clk      in  1            clock
//  reset    in  1            asynchronous, active-low reset
//  start    in  1            pulse: begin a run (ignored while busy)
//  awaddr   out ADDR_WIDTH   write address;  awlen out 8; awsize out 3; awburst out 2
//  awvalid  out 1 / awready in 1
//  wdata    out DATA_WIDTH;  wstrb out DATA_WIDTH/8 (all ones); wlast out 1
//  wvalid   out 1 / wready in 1
//  bresp    in  2;  bvalid in 1 / bready out 1
//  araddr   out ADDR_WIDTH;  arlen out 8; arsize out 3; arburst out 2
//  arvalid  out 1 / arready in 1
//  rdata    in  DATA_WIDTH;  rresp in 2; rlast in 1; rvalid in 1 / rready out 1
//  busy     out 1            run in progress
//  done     out 1            sticky: run finished; cleared by next accepted start
//  error    out 1            sticky: any mismatch/bad resp/rlast error this run
//  err_count out 16          mismatching beats this run, saturates at 'hFFFF
// BEHAVIOUR
//  - Reset (async assert): all valids/readies 0, busy/done/error 0, err_count 0, FSM IDLE, pattern reloaded.
//  - awsize/arsize = log2(DATA_WIDTH/8), awburst/arburst = INCR, awlen/arlen = BURST_LEN-1, constant.
//  - Burst n address = BASE_ADDR + n*BURST_LEN*(DATA_WIDTH/8).
//  - FSM: IDLE -start-> WR_ADDR -aw hs-> WR_DATA -last w hs-> WR_RESP -b hs-> (next burst ? WR_ADDR : RD_ADDR)
//    RD_ADDR -ar hs-> RD_DATA -r hs with beat==BURST_LEN-1-> (next burst ? RD_ADDR : DONE) ; DONE -> IDLE in 1 cycle.
//  - start accepted only in IDLE; clears done, error, err_count same edge; busy=1 next cycle.
//  - Handshake = valid&ready on rising clk. Once valid asserted, payload stable and valid held until hs.
//  - awvalid asserted the cycle after entering WR_ADDR; wvalid the cycle after aw hs; no write data before aw hs.
//  - bready=1 only in WR_RESP; rready=1 only in RD_DATA (always ready, no backpressure).
//  - wlast=1 on beat BURST_LEN-1 only. One outstanding transaction at a time.
//  - Pattern: write and read streams use separate generator instances from the same SEED,
//    advanced one step per w hs / r hs respectively; expected beat k equals written beat k.
//  - Errors (each sets error next edge): rdata!=expected (also err_count+1), bresp!=OKAY,
//    rresp!=OKAY, rlast!=(beat==BURST_LEN-1). Errors never abort the run.
//  - done and busy-fall on the same edge; done holds until reset or next start.
//  - Reset mid-run: abandons the transaction immediately (AXI slave must be reset together).
// STRUCTURE
//  - axi_pkg: AXI_RESP_OKAY/SLVERR/DECERR, AXI_BURST_INCR, state enum, clog2 helper.
//  - Sub-module axi_pattern_gen (params DATA_WIDTH, PATTERN_MODE, SEED; ports clk, reset, load, advance, data),
//    instantiated twice (write, expected-read). FSM, counters, checker in top.
// TESTING
//  - Defaults, zero-wait RAM slave, start pulse -> 32 beats total, done=1, error=0, err_count=0, addr 0x00..0x30 step 0x10.
//  - Random awready/wready/arready/rvalid stalls (0-5 cycles) -> identical result; payload stable under stall (assertion).
//  - Slave corrupts beat 5 of readback (bit 0 flipped) -> error=1, err_count=1, done=1.
//  - bresp=SLVERR on burst 2 -> error=1, err_count=0, run completes.
//  - BURST_LEN=1, NUM_BURSTS=1, DATA_WIDTH=64, PATTERN_MODE=1 -> wlast=1 every beat, pass; reset mid RD_DATA -> all outputs 0 at once.
//  - start while busy ignored; second start after done -> done/error/err_count cleared, rerun passes.

Source files
------------

// File: rtl/axi_burst_checker_pkg.sv
// Shared AXI constants, checker FSM state type and a constant-function log2 helper.
package axi_burst_checker_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef enum logic [2:0] {
        StIdle,
        StWrAddr,
        StWrData,
        StWrResp,
        StRdAddr,
        StRdData,
        StDone
    } state_e;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_pattern_gen.sv
// Test-pattern generator: either an incrementing counter from SEED or a 32-bit Galois LFSR
// replicated across DATA_WIDTH. Reloads on load, steps once per advance.
module axi_pattern_gen #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned PATTERN_MODE = 0,
    parameter logic [31:0] SEED         = 32'h1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  advance,
    output logic [DATA_WIDTH-1:0] data
);

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    if (PATTERN_MODE == 0) begin : g_inc
        logic [DATA_WIDTH-1:0] cnt_q;

        // Counter starts at SEED and bumps on every consumed beat.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_q <= DATA_WIDTH'(SEED);
            end else if (load) begin
                cnt_q <= DATA_WIDTH'(SEED);
            end else if (advance) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign data = cnt_q;
    end else begin : g_lfsr
        logic [31:0] lfsr_q;

        // LFSR state, seeded on reset and on every new run.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                lfsr_q <= SEED;
            end else if (load) begin
                lfsr_q <= SEED;
            end else if (advance) begin
                lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
            end
        end

        // Replicate the 32-bit word over the bus (truncated for narrow buses).
        always_comb begin
            data = '0;
            for (int i = 0; i < int'(DATA_WIDTH); i++) begin
                data[i] = lfsr_q[i % 32];
            end
        end
    end

endmodule

// File: rtl/axi_burst_checker.sv
// AXI4 master self-test: writes NUM_BURSTS INCR bursts of a known pattern, reads them back and
// compares every beat. Sticky done/error plus a saturating mismatch count.
module axi_burst_checker
    import axi_burst_checker_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH   = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter int unsigned           BURST_LEN    = 4,
    parameter int unsigned           NUM_BURSTS   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int unsigned           PATTERN_MODE = 0,
    parameter logic [31:0]           SEED         = 32'h1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [15:0]             err_count
);

    localparam int unsigned BYTES   = DATA_WIDTH / 8;
    localparam int unsigned SIZE    = clog2(BYTES);
    localparam int unsigned BEAT_W  = (BURST_LEN > 1) ? clog2(BURST_LEN) : 1;
    localparam int unsigned BURST_W = (NUM_BURSTS > 1) ? clog2(NUM_BURSTS) : 1;
    localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [BURST_W-1:0]    LAST_BURST  = BURST_W'(NUM_BURSTS - 1);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * BYTES);

    state_e                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q;
    logic [BURST_W-1:0]      burst_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    done_q, error_q;
    logic [15:0]             err_count_q;
    logic [DATA_WIDTH-1:0]   wr_data, rd_exp;
    logic                    start_acc, beat_last, burst_last;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic                    mismatch, err_evt;

    assign start_acc  = start && (state_q == StIdle);
    assign beat_last  = (beat_q == LAST_BEAT);
    assign burst_last = (burst_q == LAST_BURST);

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign b_hs  = bvalid && bready;
    assign ar_hs = arvalid && arready;
    assign r_hs  = rvalid && rready;

    // Burst geometry never changes during a run.
    assign awaddr  = addr_q;
    assign awlen   = 8'(BURST_LEN - 1);
    assign awsize  = 3'(SIZE);
    assign awburst = AXI_BURST_INCR;
    assign araddr  = addr_q;
    assign arlen   = 8'(BURST_LEN - 1);
    assign arsize  = 3'(SIZE);
    assign arburst = AXI_BURST_INCR;
    assign wstrb   = '1;
    assign wdata   = wr_data;

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign error     = error_q;
    assign err_count = err_count_q;

    axi_pattern_gen #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PATTERN_MODE(PATTERN_MODE),
        .SEED        (SEED)
    ) u_wr_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (start_acc),
        .advance(w_hs),
        .data   (wr_data)
    );

    axi_pattern_gen #(
        .DATA_WIDTH  (DATA_WIDTH),
        .PATTERN_MODE(PATTERN_MODE),
        .SEED        (SEED)
    ) u_rd_gen (
        .clk    (clk),
        .reset  (reset),
        .load   (start_acc),
        .advance(r_hs),
        .data   (rd_exp)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and channel valid/ready decode; valids come straight from the state register.
    always_comb begin
        state_d = state_q;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wlast   = 1'b0;
        bready  = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) state_d = StWrAddr;
            end
            StWrAddr: begin
                awvalid = 1'b1;
                if (awready) state_d = StWrData;
            end
            StWrData: begin
                wvalid = 1'b1;
                wlast  = beat_last;
                if (wready && beat_last) state_d = StWrResp;
            end
            StWrResp: begin
                bready = 1'b1;
                if (bvalid) state_d = burst_last ? StRdAddr : StWrAddr;
            end
            StRdAddr: begin
                arvalid = 1'b1;
                if (arready) state_d = StRdData;
            end
            StRdData: begin
                rready = 1'b1;
                if (rvalid && beat_last) state_d = burst_last ? StDone : StRdAddr;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Beat/burst counters and the shared write/read burst address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_q  <= '0;
            burst_q <= '0;
            addr_q  <= BASE_ADDR;
        end else if (start_acc) begin
            beat_q  <= '0;
            burst_q <= '0;
            addr_q  <= BASE_ADDR;
        end else begin
            if (w_hs || r_hs) begin
                beat_q <= beat_last ? '0 : beat_q + 1'b1;
            end
            if (b_hs) begin
                burst_q <= burst_last ? '0 : burst_q + 1'b1;
                // Last write response rewinds to the first burst for the read phase.
                addr_q  <= burst_last ? BASE_ADDR : addr_q + BURST_BYTES;
            end
            if (r_hs && beat_last) begin
                burst_q <= burst_last ? '0 : burst_q + 1'b1;
                addr_q  <= addr_q + BURST_BYTES;
            end
        end
    end

    // Per-beat checks; a bad beat is recorded but never stops the run.
    always_comb begin
        mismatch = r_hs && (rdata != rd_exp);
        err_evt  = mismatch
                 || (b_hs && (bresp != AXI_RESP_OKAY))
                 || (r_hs && ((rresp != AXI_RESP_OKAY) || (rlast != beat_last)));
    end

    // Sticky status, cleared when a new run is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_count_q <= '0;
        end else if (start_acc) begin
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (state_q == StDone) done_q <= 1'b1;
            if (err_evt) error_q <= 1'b1;
            if (mismatch && (err_count_q != 16'hFFFF)) err_count_q <= err_count_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_axi_burst_checker.sv
// Directed bench: a procedural AXI slave with RAM, stall and fault injection drives two checker
// configurations; a scoreboard queue holds expected write beats and end-of-run status.
module tb_axi_burst_checker;

    localparam logic [31:0] SEED_B    = 32'h1234_5678;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef struct packed {
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0;
    logic        rvalid = 1'b0, rlast = 1'b0;
    logic [1:0]  bresp = 2'b00, rresp = 2'b00;
    logic [63:0] rdata = '0;
    bit          sel = 1'b0;
    bit          hung = 1'b0;
    int          errors = 0, checks = 0;

    logic [31:0] a_awaddr, a_araddr, b_awaddr, b_araddr;
    logic [7:0]  a_awlen, a_arlen, b_awlen, b_arlen;
    logic [2:0]  a_awsize, a_arsize, b_awsize, b_arsize;
    logic [1:0]  a_awburst, a_arburst, b_awburst, b_arburst;
    logic        a_awvalid, a_wvalid, a_wlast, a_bready, a_arvalid, a_rready;
    logic        b_awvalid, b_wvalid, b_wlast, b_bready, b_arvalid, b_rready;
    logic [31:0] a_wdata;
    logic [63:0] b_wdata;
    logic [3:0]  a_wstrb;
    logic [7:0]  b_wstrb;
    logic        a_busy, a_done, a_error, b_busy, b_done, b_error;
    logic [15:0] a_err_count, b_err_count;

    // Selected-DUT view
    logic [31:0] m_awaddr, m_araddr;
    logic [7:0]  m_awlen, m_arlen, m_wstrb;
    logic [2:0]  m_awsize, m_arsize;
    logic [1:0]  m_awburst, m_arburst;
    logic        m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready;
    logic [63:0] m_wdata;
    logic        m_busy, m_done, m_error;
    logic [15:0] m_err_count;

    // Captured payload at handshake
    logic [31:0] s_addr;
    logic [7:0]  s_len, s_wstrb;
    logic [2:0]  s_size;
    logic [1:0]  s_burst;
    logic [63:0] s_wdata;
    logic        s_wlast;

    logic [63:0] wq[$];
    exp_t        sq[$];
    logic [63:0] mem[int unsigned];

    always #5 clk = ~clk;

    axi_burst_checker u_dut_a (
        .clk(clk), .reset(rst_n), .start(start_a),
        .awaddr(a_awaddr), .awlen(a_awlen), .awsize(a_awsize), .awburst(a_awburst),
        .awvalid(a_awvalid), .awready(awready),
        .wdata(a_wdata), .wstrb(a_wstrb), .wlast(a_wlast), .wvalid(a_wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(a_bready),
        .araddr(a_araddr), .arlen(a_arlen), .arsize(a_arsize), .arburst(a_arburst),
        .arvalid(a_arvalid), .arready(arready),
        .rdata(rdata[31:0]), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(a_rready),
        .busy(a_busy), .done(a_done), .error(a_error), .err_count(a_err_count)
    );

    axi_burst_checker #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .BURST_LEN(1), .NUM_BURSTS(1),
        .BASE_ADDR(32'h100), .PATTERN_MODE(1), .SEED(SEED_B)
    ) u_dut_b (
        .clk(clk), .reset(rst_n), .start(start_b),
        .awaddr(b_awaddr), .awlen(b_awlen), .awsize(b_awsize), .awburst(b_awburst),
        .awvalid(b_awvalid), .awready(awready),
        .wdata(b_wdata), .wstrb(b_wstrb), .wlast(b_wlast), .wvalid(b_wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(b_bready),
        .araddr(b_araddr), .arlen(b_arlen), .arsize(b_arsize), .arburst(b_arburst),
        .arvalid(b_arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(b_rready),
        .busy(b_busy), .done(b_done), .error(b_error), .err_count(b_err_count)
    );

    always_comb begin
        if (sel) begin
            m_awaddr = b_awaddr; m_awlen = b_awlen; m_awsize = b_awsize; m_awburst = b_awburst;
            m_araddr = b_araddr; m_arlen = b_arlen; m_arsize = b_arsize; m_arburst = b_arburst;
            m_awvalid = b_awvalid; m_wvalid = b_wvalid; m_wlast = b_wlast; m_bready = b_bready;
            m_arvalid = b_arvalid; m_rready = b_rready; m_wdata = b_wdata; m_wstrb = b_wstrb;
            m_busy = b_busy; m_done = b_done; m_error = b_error; m_err_count = b_err_count;
        end else begin
            m_awaddr = a_awaddr; m_awlen = a_awlen; m_awsize = a_awsize; m_awburst = a_awburst;
            m_araddr = a_araddr; m_arlen = a_arlen; m_arsize = a_arsize; m_arburst = a_arburst;
            m_awvalid = a_awvalid; m_wvalid = a_wvalid; m_wlast = a_wlast; m_bready = a_bready;
            m_arvalid = a_arvalid; m_rready = a_rready; m_wdata = {32'h0, a_wdata};
            m_wstrb = {4'h0, a_wstrb};
            m_busy = a_busy; m_done = a_done; m_error = a_error; m_err_count = a_err_count;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic vld(input int ch);
        case (ch)
            0:       return m_awvalid;
            1:       return m_wvalid;
            2:       return m_arvalid;
            3:       return m_bready;
            default: return m_rready;
        endcase
    endfunction

    function automatic logic [127:0] payload(input int ch);
        case (ch)
            0:       return {83'h0, m_awaddr, m_awlen, m_awsize, m_awburst};
            1:       return {55'h0, m_wdata, m_wstrb, m_wlast};
            default: return {83'h0, m_araddr, m_arlen, m_arsize, m_arburst};
        endcase
    endfunction

    function automatic logic [23:0] status_vec();
        return {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, m_busy, m_done, m_error,
                m_err_count};
    endfunction

    function automatic logic [63:0] pattern(input int idx);
        logic [31:0] l;
        if (!sel) return {32'h0, 32'h1 + 32'(idx)};
        l = SEED_B;
        for (int i = 0; i < idx; i++) l = {1'b0, l[31:1]} ^ (l[0] ? LFSR_POLY : 32'h0);
        return {l, l};
    endfunction

    // Bounded wait (at negedges) for a master valid/ready; expiry is a counted failure.
    task automatic wait_sig(input int ch, input string tag);
        int n = 0;
        while (!hung && !vld(ch)) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                hung = 1'b1;
                chk({"timeout_", tag}, 128'h0, 128'h1);
            end
        end
    endtask

    // Accept one AW/W/AR transfer after `stall` cycles, holding the payload under watch.
    task automatic accept(input int ch, input int stall, input string tag);
        logic [127:0] pl;
        wait_sig(ch, tag);
        if (hung) return;
        pl = payload(ch);
        repeat (stall) begin
            @(negedge clk);
            chk({tag, "_valid_held"}, 128'(vld(ch)), 128'h1);
            chk({tag, "_payload_stable"}, payload(ch), pl);
        end
        s_addr  = (ch == 2) ? m_araddr : m_awaddr;
        s_len   = (ch == 2) ? m_arlen : m_awlen;
        s_size  = (ch == 2) ? m_arsize : m_awsize;
        s_burst = (ch == 2) ? m_arburst : m_awburst;
        s_wdata = m_wdata;
        s_wstrb = m_wstrb;
        s_wlast = m_wlast;
        case (ch)
            0:       awready = 1'b1;
            1:       wready = 1'b1;
            default: arready = 1'b1;
        endcase
        @(negedge clk);
        awready = 1'b0;
        wready  = 1'b0;
        arready = 1'b0;
    endtask

    task automatic send_b(input int stall, input logic [1:0] resp);
        wait_sig(3, "bready");
        if (hung) return;
        repeat (stall) @(negedge clk);
        bvalid = 1'b1;
        bresp  = resp;
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = 2'b00;
    endtask

    task automatic send_r(input int stall, input logic [63:0] d, input logic last);
        wait_sig(4, "rready");
        if (hung) return;
        repeat (stall) @(negedge clk);
        rvalid = 1'b1;
        rdata  = d;
        rlast  = last;
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        chk("start_clears", {104'h0, m_busy, m_done, m_error, m_err_count}, {104'h0, 19'h40000});
    endtask

    // One complete run: scoreboard filled at start, slave serves every channel in order.
    task automatic run(input int bl, input int nb, input int bytes, input logic [31:0] base,
                       input int stall_max, input int corrupt, input int slverr,
                       input bit poke, input bit abort_rd);
        logic [31:0] base_b;
        logic [63:0] d, e;
        exp_t        x;
        int          n;
        if (hung) return;
        for (int i = 0; i < bl * nb; i++) wq.push_back(pattern(i));
        sq.push_back('{err: (corrupt >= 0 || slverr >= 0), cnt: 16'(corrupt >= 0 ? 1 : 0)});
        pulse_start();
        for (int b = 0; b < nb; b++) begin
            accept(0, $urandom_range(stall_max, 0), "aw");
            if (hung) return;
            base_b = s_addr;
            chk("awaddr", 128'(s_addr), 128'(base + 32'(b * bl * bytes)));
            chk("awlen", 128'(s_len), 128'(bl - 1));
            chk("awsize", 128'(s_size), 128'($clog2(bytes)));
            chk("awburst", 128'(s_burst), 128'h1);
            for (int k = 0; k < bl; k++) begin
                accept(1, $urandom_range(stall_max, 0), "w");
                if (hung) return;
                e = (wq.size() > 0) ? wq.pop_front() : 64'hx;
                chk("wdata", 128'(s_wdata), 128'(e));
                chk("wstrb", 128'(s_wstrb), sel ? 128'hFF : 128'h0F);
                chk("wlast", 128'(s_wlast), 128'(k == bl - 1));
                mem[base_b + 32'(k * bytes)] = s_wdata;
            end
            send_b($urandom_range(stall_max, 0), (b == slverr) ? 2'b10 : 2'b00);
            if (poke && b == 0) begin
                if (sel) start_b = 1'b1; else start_a = 1'b1;
                @(negedge clk);
                start_a = 1'b0;
                start_b = 1'b0;
                chk("start_ignored", {126'h0, m_busy, m_done}, 128'h2);
            end
        end
        for (int b = 0; b < nb; b++) begin
            accept(2, $urandom_range(stall_max, 0), "ar");
            if (hung) return;
            base_b = s_addr;
            chk("araddr", 128'(s_addr), 128'(base + 32'(b * bl * bytes)));
            chk("arlen", 128'(s_len), 128'(bl - 1));
            chk("arsize", 128'(s_size), 128'($clog2(bytes)));
            if (abort_rd) begin
                wait_sig(4, "rready_abort");
                rst_n = 1'b0;
                #1;
                chk("reset_mid_read", 128'(status_vec()), 128'h0);
                void'(sq.pop_back());
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            for (int k = 0; k < bl; k++) begin
                d = mem.exists(base_b + 32'(k * bytes)) ? mem[base_b + 32'(k * bytes)] : 64'h0;
                if (b * bl + k == corrupt) d = d ^ 64'h1;
                send_r($urandom_range(stall_max, 0), d, (k == bl - 1));
            end
        end
        n = 0;
        while (!m_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        x = sq.pop_front();
        chk("done", 128'(m_done), 128'h1);
        chk("busy_low", 128'(m_busy), 128'h0);
        chk("error", 128'(m_error), 128'(x.err));
        chk("err_count", 128'(m_err_count), 128'(x.cnt));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        sel = 1'b0;
        chk("reset_a", 128'(status_vec()), 128'h0);
        sel = 1'b1;
        #1;
        chk("reset_b", 128'(status_vec()), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;

        sel = 1'b0;
        run(4, 4, 4, 32'h0, 0, -1, -1, 1'b0, 1'b0);   // clean, zero wait
        run(4, 4, 4, 32'h0, 5, -1, -1, 1'b0, 1'b0);   // random stalls
        run(4, 4, 4, 32'h0, 2, 5, -1, 1'b0, 1'b0);    // beat 5 corrupted
        run(4, 4, 4, 32'h0, 0, -1, 2, 1'b0, 1'b0);    // SLVERR on burst 2
        run(4, 4, 4, 32'h0, 1, -1, -1, 1'b1, 1'b0);   // start while busy, rerun clean

        sel = 1'b1;
        #1;
        run(1, 1, 8, 32'h100, 0, -1, -1, 1'b0, 1'b0);
        run(1, 1, 8, 32'h100, 3, 0, -1, 1'b0, 1'b0);
        run(1, 1, 8, 32'h100, 0, -1, -1, 1'b0, 1'b1); // reset while in RD_DATA
        run(1, 1, 8, 32'h100, 0, -1, -1, 1'b0, 1'b0); // recovers after reset

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
